gemm_hls_deadlock_reporter: RTL and testbench
=============================================

// Module: gemm_hls_deadlock_reporter
// PURPOSE
//  Consumer end of the gemm_inst deadlock monitor chain. Takes the monitor's
//  per-cycle block flag plus raw axis/idle status and filters transient blocks.
//  A block that persists is latched as a deadlock event, snapshotted and raised
//  to the host as an interrupt. The event is held until the host acknowledges it.
//  Sits beside gemm_gemm_inst; its outputs feed the control/status register bank.
// PARAMETERS
//  CONFIRM_CYCLES  16  consecutive block cycles needed to declare deadlock (>=1)
//  AXIS_W          4   width of axis_block_sigs
//  IDLE_W          4   width of inst_idle_sigs
//  CNT_W           8   width of the saturating deadlock event counter
// PORTS
//  clock            in   1       single clock, all logic on posedge
//  reset_n          in   1       asynchronous, active-low reset
//  block            in   1       registered block flag from the deadlock monitor
//  axis_block_sigs  in   AXIS_W  raw per-axis block status (snapshot source)
//  inst_idle_sigs   in   IDLE_W  raw per-instance idle status (snapshot source)
//  ack              in   1       host acknowledge; sampled only in REPORTED
//  deadlock_valid   out  1       deadlock latched and not yet acknowledged
//  deadlock_axis    out  AXIS_W  axis_block_sigs captured at confirmation
//  deadlock_idle    out  IDLE_W  inst_idle_sigs captured at confirmation
//  deadlock_count   out  CNT_W   confirmed events since reset, saturating
//  irq              out  1       one-cycle pulse on each new confirmation
// BEHAVIOUR
//  Reset (reset_n=0, async):
//   - state=IDLE, run counter=0.
//   - All outputs 0: deadlock_valid, deadlock_axis, deadlock_idle, deadlock_count, irq.
//  Run counter is $clog2(CONFIRM_CYCLES+1) bits wide; it counts consecutive sampled block=1.
//  FSM:
//   IDLE:
//    - block=1, CONFIRM_CYCLES==1: go to REPORTED.
//    - block=1, otherwise: go to CONFIRM with cnt=1.
//   CONFIRM:
//    - block=0: go to IDLE, cnt=0.
//    - block=1: cnt++.
//    - When the edge brings cnt to CONFIRM_CYCLES, go to REPORTED.
//   Entering REPORTED, at the Nth consecutive block=1 edge:
//    - Snapshot axis_block_sigs and inst_idle_sigs from that edge into the outputs.
//    - deadlock_valid=1 and irq=1 for exactly that next cycle.
//    - deadlock_count += 1, held at 2^CNT_W-1 once reached.
//   REPORTED: outputs held stable; block is ignored. On ack=1:
//    - block=1 on the same edge: go to WAIT_CLEAR.
//    - block=0 on the same edge: go to IDLE.
//    - deadlock_valid clears on that edge. Snapshot regs keep their value until
//      the next confirmation.
//   WAIT_CLEAR:
//    - block=0: go to IDLE.
//    - No re-report while the same block episode persists.
//  Latency: block high from edge k gives deadlock_valid/irq high after edge
//   k+CONFIRM_CYCLES-1, i.e. N edges sampled.
//  ack outside REPORTED is ignored. ack held high continuously acknowledges
//   each event in the cycle after its irq.
//  irq never asserts while deadlock_valid is already 1. At most one irq per
//   block episode.
//  Async reset mid-CONFIRM or mid-REPORTED discards the pending or latched
//   event; the counter is cleared too.
// TESTING
//  - Reset: hold reset_n=0 with block=1 -> all outputs 0; after release with
//    N=16 and block=1, deadlock_valid rises after the 16th edge.
//  - Glitch filter: N=16, block high 15 cycles, low 1, high 15 -> no irq,
//    deadlock_count=0.
//  - Confirm: N=4, block=1, axis=4'b1001, idle=4'b0010 -> irq one cycle after
//    4 edges; deadlock_axis=1001, deadlock_idle=0010, count=1.
//  - ack with block still 1 -> valid=0 next edge, no new irq until block=0 for
//    >=1 cycle; then 4 more block cycles -> irq, count=2.
//  - Saturation: CNT_W=2, 5 episodes -> count reads 1,2,3,3,3; irq on all 5.
//  - N=1 edge case plus async reset in REPORTED -> valid=0 immediately and
//    count=0; the next block cycle re-raises irq.

Source files
------------

// File: rtl/gemm_hls_deadlock_reporter.sv
// Deadlock reporter for the gemm_inst monitor chain: filters transient block
// flags, latches persistent ones as events, snapshots status and raises an irq.
module gemm_hls_deadlock_reporter #(
    parameter int CONFIRM_CYCLES = 16,
    parameter int AXIS_W         = 4,
    parameter int IDLE_W         = 4,
    parameter int CNT_W          = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              block,
    input  logic [AXIS_W-1:0] axis_block_sigs,
    input  logic [IDLE_W-1:0] inst_idle_sigs,
    input  logic              ack,
    output logic              deadlock_valid,
    output logic [AXIS_W-1:0] deadlock_axis,
    output logic [IDLE_W-1:0] deadlock_idle,
    output logic [CNT_W-1:0]  deadlock_count,
    output logic              irq
);

    localparam int RUN_W = $clog2(CONFIRM_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(CONFIRM_CYCLES);
    localparam logic [CNT_W-1:0] COUNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONFIRM,
        S_REPORTED,
        S_WAIT_CLEAR
    } state_t;

    state_t           state, state_next;
    logic [RUN_W-1:0] run, run_next;
    logic [RUN_W-1:0] run_inc;
    logic             confirm;

    assign run_inc = run + RUN_W'(1);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_next = state;
        run_next   = run;
        confirm    = 1'b0;
        case (state)
            // run is zero in IDLE, so IDLE and CONFIRM share the counting path.
            S_IDLE, S_CONFIRM: begin
                if (!block) begin
                    state_next = S_IDLE;
                    run_next   = '0;
                end else if (run_inc == RUN_TARGET) begin
                    state_next = S_REPORTED;
                    run_next   = '0;
                    confirm    = 1'b1;
                end else begin
                    state_next = S_CONFIRM;
                    run_next   = run_inc;
                end
            end
            S_REPORTED: begin
                if (ack) begin
                    state_next = block ? S_WAIT_CLEAR : S_IDLE;
                end
            end
            S_WAIT_CLEAR: begin
                if (!block) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                run_next   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            run            <= '0;
            deadlock_valid <= 1'b0;
            irq            <= 1'b0;
            deadlock_axis  <= '0;
            deadlock_idle  <= '0;
            deadlock_count <= '0;
        end else begin
            state          <= state_next;
            run            <= run_next;
            deadlock_valid <= (state_next == S_REPORTED);
            irq            <= confirm;
            if (confirm) begin
                deadlock_axis <= axis_block_sigs;
                deadlock_idle <= inst_idle_sigs;
                if (deadlock_count != COUNT_MAX) begin
                    deadlock_count <= deadlock_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gemm_hls_deadlock_reporter.sv
// Bench for gemm_hls_deadlock_reporter: three configurations (N=16/4/1) share
// stimulus; directed tables and sequences plus a randomized episode-level model.
module tb_gemm_hls_deadlock_reporter;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       block = 1'b0;
    logic       ack = 1'b0;
    logic [3:0] axis_sigs = 4'h0;
    logic [3:0] idle_sigs = 4'h0;

    logic       v16, i16, v4, i4, v1, i1;
    logic [3:0] ax16, id16, ax4, id4, ax1, id1;
    logic [7:0] c16;
    logic [1:0] c4;
    logic [2:0] c1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    gemm_hls_deadlock_reporter #(.CONFIRM_CYCLES(16), .AXIS_W(4), .IDLE_W(4), .CNT_W(8)) u_n16 (
        .clock(clock), .reset_n(reset_n), .block(block), .axis_block_sigs(axis_sigs),
        .inst_idle_sigs(idle_sigs), .ack(ack), .deadlock_valid(v16), .deadlock_axis(ax16),
        .deadlock_idle(id16), .deadlock_count(c16), .irq(i16));

    gemm_hls_deadlock_reporter #(.CONFIRM_CYCLES(4), .AXIS_W(4), .IDLE_W(4), .CNT_W(2)) u_n4 (
        .clock(clock), .reset_n(reset_n), .block(block), .axis_block_sigs(axis_sigs),
        .inst_idle_sigs(idle_sigs), .ack(ack), .deadlock_valid(v4), .deadlock_axis(ax4),
        .deadlock_idle(id4), .deadlock_count(c4), .irq(i4));

    gemm_hls_deadlock_reporter #(.CONFIRM_CYCLES(1), .AXIS_W(4), .IDLE_W(4), .CNT_W(3)) u_n1 (
        .clock(clock), .reset_n(reset_n), .block(block), .axis_block_sigs(axis_sigs),
        .inst_idle_sigs(idle_sigs), .ack(ack), .deadlock_valid(v1), .deadlock_axis(ax1),
        .deadlock_idle(id1), .deadlock_count(c1), .irq(i1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic b, input logic a, input logic [3:0] ax, input logic [3:0] id);
        block     = b;
        ack       = a;
        axis_sigs = ax;
        idle_sigs = id;
    endtask

    task automatic do_reset(input logic b);
        drive(b, 1'b0, 4'hF, 4'hF);
        reset_n = 1'b0;
        step();
        step();
        check("rst_valid", {29'd0, v16, v4, v1}, 32'd0);
        check("rst_irq",   {29'd0, i16, i4, i1}, 32'd0);
        check("rst_count", {19'd0, c16, c4, c1}, 32'd0);
        check("rst_snap",  {8'd0, ax16, id16, ax4, id4, ax1, id1}, 32'd0);
        reset_n = 1'b1;
    endtask

    // Table-driven sequence for the N=4 instance (values applied before each edge).
    typedef struct {
        logic       b;
        logic       a;
        logic [3:0] ax;
        logic [3:0] id;
        logic       ev;
        logic       eirq;
        logic [1:0] ecnt;
        logic [3:0] eax;
        logic [3:0] eid;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic b, logic a, logic [3:0] ax, logic [3:0] id,
                                logic ev, logic eirq, logic [1:0] ecnt,
                                logic [3:0] eax, logic [3:0] eid);
        vec_t r;
        r.b = b; r.a = a; r.ax = ax; r.id = id;
        r.ev = ev; r.eirq = eirq; r.ecnt = ecnt; r.eax = eax; r.eid = eid;
        return r;
    endfunction

    // Episode-level reference: run length of block, a latched event and whether
    // the current block episode has already been reported.
    int         n_cfg[3]  = '{16, 4, 1};
    int         max_cnt[3] = '{255, 3, 7};
    logic       m_valid[3];
    logic       m_irq[3];
    logic       m_reported[3];
    int         m_run[3];
    int         m_count[3];
    logic [3:0] m_ax[3];
    logic [3:0] m_id[3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_valid[k] = 1'b0; m_irq[k] = 1'b0; m_reported[k] = 1'b0;
            m_run[k] = 0; m_count[k] = 0; m_ax[k] = 4'h0; m_id[k] = 4'h0;
        end
    endtask

    task automatic model_edge(input logic b, input logic a, input logic [3:0] ax, input logic [3:0] id);
        for (int k = 0; k < 3; k++) begin
            m_irq[k] = 1'b0;
            if (m_valid[k]) begin
                if (a) begin
                    m_valid[k]    = 1'b0;
                    m_reported[k] = b;
                    m_run[k]      = 0;
                end
            end else if (!b) begin
                m_run[k]      = 0;
                m_reported[k] = 1'b0;
            end else if (!m_reported[k]) begin
                m_run[k]++;
                if (m_run[k] == n_cfg[k]) begin
                    m_valid[k]    = 1'b1;
                    m_irq[k]      = 1'b1;
                    m_reported[k] = 1'b1;
                    m_run[k]      = 0;
                    m_ax[k]       = ax;
                    m_id[k]       = id;
                    if (m_count[k] < max_cnt[k]) m_count[k]++;
                end
            end
        end
    endtask

    task automatic model_compare();
        check("rnd_valid16", v16, m_valid[0]);
        check("rnd_irq16",   i16, m_irq[0]);
        check("rnd_count16", c16, m_count[0]);
        check("rnd_snap16",  {ax16, id16}, {m_ax[0], m_id[0]});
        check("rnd_valid4",  v4, m_valid[1]);
        check("rnd_irq4",    i4, m_irq[1]);
        check("rnd_count4",  c4, m_count[1]);
        check("rnd_snap4",   {ax4, id4}, {m_ax[1], m_id[1]});
        check("rnd_valid1",  v1, m_valid[2]);
        check("rnd_irq1",    i1, m_irq[2]);
        check("rnd_count1",  c1, m_count[2]);
        check("rnd_snap1",   {ax1, id1}, {m_ax[2], m_id[2]});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with block=1, then 16 consecutive block edges on N=16.
        #1;
        do_reset(1'b1);
        for (int i = 1; i <= 16; i++) begin
            step();
            check("n16_latency_valid", v16, (i == 16));
            check("n16_latency_irq",   i16, (i == 16));
        end
        check("n16_first_count", c16, 8'd1);

        // Glitch filter: 15 high, 1 low, 15 high, 1 low -> never confirms.
        do_reset(1'b0);
        for (int i = 0; i < 32; i++) begin
            drive((i != 15) && (i != 31), 1'b0, 4'h5, 4'hA);
            step();
            check("n16_glitch_irq", i16, 1'b0);
        end
        check("n16_glitch_count", c16, 8'd0);

        // Table: confirm, ack with block held, re-arm after a low cycle.
        tbl[0]  = mk(1, 0, 4'h9, 4'h2, 0, 0, 2'd0, 4'h0, 4'h0);
        tbl[1]  = mk(1, 0, 4'h9, 4'h2, 0, 0, 2'd0, 4'h0, 4'h0);
        tbl[2]  = mk(1, 0, 4'h9, 4'h2, 0, 0, 2'd0, 4'h0, 4'h0);
        tbl[3]  = mk(1, 0, 4'h9, 4'h2, 1, 1, 2'd1, 4'h9, 4'h2);
        tbl[4]  = mk(1, 0, 4'h6, 4'h7, 1, 0, 2'd1, 4'h9, 4'h2);
        tbl[5]  = mk(1, 1, 4'h6, 4'h7, 0, 0, 2'd1, 4'h9, 4'h2);
        tbl[6]  = mk(1, 0, 4'h6, 4'h7, 0, 0, 2'd1, 4'h9, 4'h2);
        tbl[7]  = mk(1, 1, 4'h6, 4'h7, 0, 0, 2'd1, 4'h9, 4'h2);
        tbl[8]  = mk(1, 0, 4'h6, 4'h7, 0, 0, 2'd1, 4'h9, 4'h2);
        tbl[9]  = mk(1, 0, 4'h6, 4'h7, 0, 0, 2'd1, 4'h9, 4'h2);
        tbl[10] = mk(0, 0, 4'h6, 4'h7, 0, 0, 2'd1, 4'h9, 4'h2);
        tbl[11] = mk(1, 0, 4'h6, 4'h7, 0, 0, 2'd1, 4'h9, 4'h2);
        tbl[12] = mk(1, 0, 4'h6, 4'h7, 0, 0, 2'd1, 4'h9, 4'h2);
        tbl[13] = mk(1, 0, 4'h6, 4'h7, 0, 0, 2'd1, 4'h9, 4'h2);
        tbl[14] = mk(1, 0, 4'h3, 4'hC, 1, 1, 2'd2, 4'h3, 4'hC);
        tbl[15] = mk(0, 1, 4'h0, 4'h0, 0, 0, 2'd2, 4'h3, 4'hC);
        do_reset(1'b0);
        for (int r = 0; r < 16; r++) begin
            drive(tbl[r].b, tbl[r].a, tbl[r].ax, tbl[r].id);
            step();
            check($sformatf("tbl%0d_valid", r), v4, tbl[r].ev);
            check($sformatf("tbl%0d_irq", r),   i4, tbl[r].eirq);
            check($sformatf("tbl%0d_count", r), c4, tbl[r].ecnt);
            check($sformatf("tbl%0d_axis", r),  ax4, tbl[r].eax);
            check($sformatf("tbl%0d_idle", r),  id4, tbl[r].eid);
        end

        // Saturation on the 2-bit counter: episodes 3..5 read 3 and still irq.
        for (int ep = 3; ep <= 5; ep++) begin
            for (int j = 0; j < 4; j++) begin
                drive(1'b1, 1'b0, 4'h1, 4'h1);
                step();
                check("sat_irq", i4, (j == 3));
            end
            check("sat_count", c4, 2'd3);
            drive(1'b0, 1'b1, 4'h0, 4'h0);
            step();
            check("sat_ack_valid", v4, 1'b0);
        end

        // N=1: confirm on the first edge, async reset in REPORTED, re-raise.
        do_reset(1'b0);
        drive(1'b1, 1'b0, 4'hB, 4'h4);
        step();
        check("n1_valid", v1, 1'b1);
        check("n1_irq",   i1, 1'b1);
        check("n1_count", c1, 3'd1);
        check("n1_snap",  {ax1, id1}, 8'hB4);
        #2;
        reset_n = 1'b0;
        #1;
        check("n1_async_valid", v1, 1'b0);
        check("n1_async_count", c1, 3'd0);
        check("n1_async_irq",   i1, 1'b0);
        reset_n = 1'b1;
        step();
        check("n1_rearm_irq",   i1, 1'b1);
        check("n1_rearm_count", c1, 3'd1);
        step();
        check("n1_hold_irq",    i1, 1'b0);
        check("n1_hold_valid",  v1, 1'b1);

        // Randomized run against the episode-level model, with occasional async resets.
        do_reset(1'b0);
        model_reset();
        begin
            logic b = 1'b0;
            for (int cyc = 0; cyc < 2000; cyc++) begin
                logic       a;
                logic [3:0] ax, id;
                if ($urandom_range(0, 19) == 0) b = ~b;
                a  = ($urandom_range(0, 3) == 0);
                ax = 4'($urandom);
                id = 4'($urandom);
                if ($urandom_range(0, 299) == 0) begin
                    reset_n = 1'b0;
                    #2;
                    model_reset();
                    check("rnd_async_valid", {29'd0, v16, v4, v1}, 32'd0);
                    reset_n = 1'b1;
                end
                drive(b, a, ax, id);
                step();
                model_edge(b, a, ax, id);
                model_compare();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
